// File: rtl/rom_arbiter.sv
// Two-port (instruction fetch / data load) arbiter in front of a one-cycle synchronous ROM.
// Define ROM_ARB_RR_EN for round-robin tie-breaking; otherwise the D port wins ties.
module rom_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic                  rom_rdata_valid
);

    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    logic                  pending;
    port_t                 pend_port;
    port_t                 rr_last;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0] hold_i;
    logic [DATA_WIDTH-1:0] hold_d;

    logic can_grant;
    logic tie;
    logic pick_d;
    logic resp;

    always_comb begin
        can_grant = !pending || rom_rdata_valid;
        tie       = i_req && d_req;
`ifdef ROM_ARB_RR_EN
        pick_d    = (rr_last == PORT_I);
`else
        // rr_last keeps tracking the last grant but fixed priority ignores it.
        pick_d    = (rr_last == PORT_I) || 1'b1;
`endif
        i_gnt     = !rst && can_grant && i_req && !(tie && pick_d);
        d_gnt     = !rst && can_grant && d_req && !(tie && !pick_d);

        // A stalled or idle ROM keeps seeing the last issued address.
        if (i_gnt)
            rom_addr = i_addr;
        else if (d_gnt)
            rom_addr = d_addr;
        else
            rom_addr = pend_addr;

        resp      = !rst && pending && rom_rdata_valid;
        i_rvalid  = resp && (pend_port == PORT_I);
        d_rvalid  = resp && (pend_port == PORT_D);
        i_rdata   = i_rvalid ? rom_rdata : hold_i;
        d_rdata   = d_rvalid ? rom_rdata : hold_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            pend_port <= PORT_I;
            rr_last   <= PORT_D;
            pend_addr <= '0;
            hold_i    <= '0;
            hold_d    <= '0;
        end else begin
            if (i_rvalid)
                hold_i <= rom_rdata;
            if (d_rvalid)
                hold_d <= rom_rdata;

            if (i_gnt || d_gnt) begin
                pending   <= 1'b1;
                pend_port <= d_gnt ? PORT_D : PORT_I;
                rr_last   <= d_gnt ? PORT_D : PORT_I;
                pend_addr <= rom_addr;
            end else if (rom_rdata_valid) begin
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester arbiter sharing the single synchronous-read boot/program ROM between the core's instruction-fetch port (I) and data-load port (D). Sits between the core's memory ports and the ROM. Drives the ROM address from the granted requester, tracks the one-cycle read latency, and routes each returned word to the port that issued it. Fully pipelined: one grant per cycle while the ROM reports valid data.

## Interface
Parameters:
- DATA_WIDTH, 32, ROM word width
- ADDR_WIDTH, 10, ROM word-address width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction-fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_WIDTH  instruction word address
- i_gnt  out  1  request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  DATA_WIDTH  returned word; holds last delivered value otherwise
- d_req, d_addr, d_gnt, d_rvalid, d_rdata: same as I port, for data loads
- rom_addr  out  ADDR_WIDTH  to ROM addr
- rom_rdata  in  DATA_WIDTH  from ROM rdata, word for address sampled on previous edge
- rom_rdata_valid  in  1  from ROM; qualifies rom_rdata in a response cycle

## Operation
- State: pending (1 bit), pend_port (I/D), pend_addr, rr_last (last granted port), i/d hold registers.
- can_grant = !pending || rom_rdata_valid.
- Arbitration when can_grant: only one req -> grant it; both -> per Configuration. At most one gnt per cycle; gnt never asserted without matching req.
- On grant: rom_addr = granted addr (combinational); next edge pending<=1, pend_port<=port, pend_addr<=addr, rr_last<=port.
- Response cycle (pending=1):
  - rom_rdata_valid=1: assert <pend_port>_rvalid, <pend_port>_rdata = rom_rdata, latch into that port's hold register; pending clears unless a new grant occurs in the same cycle (back-to-back).
  - rom_rdata_valid=0: stall; no rvalid, no grant, rom_addr = pend_addr, pending stays 1.
- Idle (pending=0, no grant): rom_addr = pend_addr (last issued address).
- Non-granted requester keeps req/addr asserted; arbiter never drops a request.

## Timing
- Reset values: pending=0, rr_last=D (so I wins first tie), pend_addr=0, hold registers=0; all gnt/rvalid = 0, i_rdata=d_rdata=0, rom_addr=0. gnt outputs forced 0 while rst=1.
- Latency: grant in cycle N -> rvalid in cycle N+1 (rom_rdata_valid=1), else first later cycle with rom_rdata_valid=1.
- Throughput: one word per cycle with both requesters active and ROM always valid.
- Response and new grant in same cycle allowed, including same port consecutively.
- Reset mid-transaction: pending dropped, no rvalid issued for it; requester re-issues.

## Configuration
- ROM_ARB_RR_EN defined: round-robin on tie; grant the port not equal to rr_last.
- Undefined: fixed priority, D always wins a tie (I may starve under continuous D traffic); rr_last still updated but unused.

## Test plan
- Reset then i_req=1, i_addr=0x004, ROM word 0x00000013 -> i_gnt in cycle 0, i_rvalid=1 with i_rdata=0x00000013 in cycle 1; d_rvalid stays 0; i_rdata holds 0x00000013 afterwards.
- I streaming addrs 0..7 with req held -> gnt every cycle, 8 consecutive rvalids carrying words 0..7 in order.
- Both req every cycle, I addr 0x010, D addr 0x020: without ROM_ARB_RR_EN -> d_gnt every cycle, i_gnt never; with it -> first grant I, then alternating D, I, D.
- Grant D addr 0x030, hold rom_rdata_valid=0 for 3 cycles -> no gnt, rom_addr=0x030 throughout, d_rvalid on the cycle valid returns, next grant in that same cycle.
- Grant I, assert rst in response cycle -> no i_rvalid, all outputs at reset values next cycle; re-issued request completes normally.
